control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 158 +++++++++++++++
 tb/tb_control_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multi-cycle control unit: BOOT -> FETCH -> DECODE -> EXECUTE, with HALT on illegal opcodes.
// State and the retired-instruction counter are registered; control outputs are decoded
// combinationally from the current state and the opcode presented in that cycle.
module control_unit #(
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [6:0]             opcode,
  input  logic [2:0]             funct3,
  input  logic [6:0]             funct7,
  output logic                   sub,
  output logic                   WE_RF,
  output logic                   WE_MEM,
  output logic [1:0]             RF_din_sel,
  output logic                   ULA_din2_sel,
  output logic                   load_pc,
  output logic                   reset_pc,
  output logic                   pc_next_sel,
  output logic                   pc_adder_sel,
  output logic                   reset_ir,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] retired
);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpIAlu   = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [COUNT_WIDTH-1:0] CountOne = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    StBoot,
    StFetch,
    StDecode,
    StExecute,
    StHalt
  } state_e;

  state_e state_q;
  logic   opcode_legal;

  // Opcode classes the datapath can execute; anything else halts the machine.
  always_comb begin
    opcode_legal = 1'b0;
    unique case (opcode)
      OpR, OpIAlu, OpLoad, OpStore, OpBranch, OpJal, OpJalr, OpAuipc: opcode_legal = 1'b1;
      default: opcode_legal = 1'b0;
    endcase
  end

  // State sequencing and retired counter; reset wins from every state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StBoot;
      retired <= '0;
    end else begin
      unique case (state_q)
        StBoot:    state_q <= StFetch;
        StFetch:   state_q <= StDecode;
        StDecode:  state_q <= opcode_legal ? StExecute : StHalt;
        StExecute: begin
          state_q <= StFetch;
          retired <= retired + CountOne;
        end
        StHalt:    state_q <= StHalt;
        default:   state_q <= StBoot;
      endcase
    end
  end

  // Control decode; RST forces the BOOT values so outputs are defined before the first edge.
  always_comb begin
    sub          = 1'b0;
    WE_RF        = 1'b0;
    WE_MEM       = 1'b0;
    RF_din_sel   = 2'b00;
    ULA_din2_sel = 1'b0;
    load_pc      = 1'b0;
    reset_pc     = 1'b0;
    pc_next_sel  = 1'b0;
    pc_adder_sel = 1'b0;
    reset_ir     = 1'b0;
    halted       = 1'b0;
    if (RST) begin
      reset_pc = 1'b1;
      reset_ir = 1'b1;
    end else begin
      unique case (state_q)
        StBoot: begin
          reset_pc = 1'b1;
          reset_ir = 1'b1;
        end
        StHalt: halted = 1'b1;
        StExecute: begin
          // Decoded from the opcode present now, not the one seen in DECODE.
          unique case (opcode)
            OpR: begin
              load_pc    = 1'b1;
              WE_RF      = 1'b1;
              RF_din_sel = 2'b01;
              sub        = (funct3 == 3'b000) && (funct7 == 7'b0100000);
            end
            OpIAlu: begin
              load_pc      = 1'b1;
              WE_RF        = 1'b1;
              RF_din_sel   = 2'b01;
              ULA_din2_sel = 1'b1;
            end
            OpLoad: begin
              load_pc      = 1'b1;
              WE_RF        = 1'b1;
              RF_din_sel   = 2'b00;
              ULA_din2_sel = 1'b1;
            end
            OpStore: begin
              load_pc      = 1'b1;
              WE_MEM       = 1'b1;
              ULA_din2_sel = 1'b1;
            end
            OpBranch: begin
              load_pc     = 1'b1;
              sub         = 1'b1;
              pc_next_sel = 1'b1;
            end
            OpJal: begin
              load_pc     = 1'b1;
              WE_RF       = 1'b1;
              RF_din_sel  = 2'b10;
              pc_next_sel = 1'b1;
            end
            OpJalr: begin
              load_pc      = 1'b1;
              WE_RF        = 1'b1;
              RF_din_sel   = 2'b10;
              ULA_din2_sel = 1'b1;
              pc_next_sel  = 1'b1;
              pc_adder_sel = 1'b1;
            end
            OpAuipc: begin
              load_pc    = 1'b1;
              WE_RF      = 1'b1;
              RF_din_sel = 2'b11;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a stimulus process drives one cycle at a time and pushes
// the behaviourally expected outputs; a negedge monitor pops and compares against the DUT.
module tb_control_unit;

  localparam int unsigned W = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [6:0]   opcode = '0;
  logic [2:0]   funct3 = '0;
  logic [6:0]   funct7 = '0;
  logic         sub, WE_RF, WE_MEM, ULA_din2_sel, load_pc, reset_pc;
  logic         pc_next_sel, pc_adder_sel, reset_ir, halted;
  logic [1:0]   RF_din_sel;
  logic [W-1:0] retired;

  control_unit #(.COUNT_WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .sub(sub), .WE_RF(WE_RF), .WE_MEM(WE_MEM), .RF_din_sel(RF_din_sel),
    .ULA_din2_sel(ULA_din2_sel), .load_pc(load_pc), .reset_pc(reset_pc),
    .pc_next_sel(pc_next_sel), .pc_adder_sel(pc_adder_sel), .reset_ir(reset_ir),
    .halted(halted), .retired(retired)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       sub, we_rf, we_mem;
    logic [1:0] rf_sel;
    logic       ula, load_pc, reset_pc, pc_next, pc_adder, reset_ir, halted;
  } ctl_t;

  typedef struct {
    ctl_t       ctl;
    logic [W-1:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: which phase of an instruction we are in and how many have completed.
  localparam int PhBoot = 0, PhFetch = 1, PhDecode = 2, PhExec = 3, PhHalt = 4;
  int phase = PhBoot;
  int done_count = 0;

  localparam logic [6:0] LegalOps [8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                          7'b1100011, 7'b1101111, 7'b1100111, 7'b0010111};

  function automatic bit is_legal(input logic [6:0] op);
    foreach (LegalOps[i]) if (LegalOps[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Expected controls straight from the instruction-class table.
  function automatic ctl_t model_ctl(input bit rst, input int ph, input logic [6:0] op,
                                     input logic [2:0] f3, input logic [6:0] f7);
    ctl_t c = '0;
    if (rst || ph == PhBoot) begin
      c.reset_pc = 1'b1;
      c.reset_ir = 1'b1;
      return c;
    end
    if (ph == PhHalt) begin
      c.halted = 1'b1;
      return c;
    end
    if (ph != PhExec || !is_legal(op)) return c;
    c.load_pc = 1'b1;
    case (op)
      7'b0110011: begin c.we_rf = 1; c.rf_sel = 2'd1; c.sub = (f3 == 0 && f7 == 7'h20); end
      7'b0010011: begin c.we_rf = 1; c.rf_sel = 2'd1; c.ula = 1; end
      7'b0000011: begin c.we_rf = 1; c.rf_sel = 2'd0; c.ula = 1; end
      7'b0100011: begin c.we_mem = 1; c.ula = 1; end
      7'b1100011: begin c.sub = 1; c.pc_next = 1; end
      7'b1101111: begin c.we_rf = 1; c.rf_sel = 2'd2; c.pc_next = 1; end
      7'b1100111: begin c.we_rf = 1; c.rf_sel = 2'd2; c.ula = 1; c.pc_next = 1; c.pc_adder = 1; end
      default:    begin c.we_rf = 1; c.rf_sel = 2'd3; end
    endcase
    return c;
  endfunction

  // One clock: drive, predict, advance the model across the edge.
  task automatic cycle(input bit rst, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7);
    exp_t e;
    RST = rst; opcode = op; funct3 = f3; funct7 = f7;
    e.ctl = model_ctl(rst, phase, op, f3, f7);
    e.ret = W'(done_count);
    exp_q.push_back(e);
    @(posedge CLK);
    if (rst) begin
      phase = PhBoot;
      done_count = 0;
    end else begin
      case (phase)
        PhBoot:   phase = PhFetch;
        PhFetch:  phase = PhDecode;
        PhDecode: phase = is_legal(op) ? PhExec : PhHalt;
        PhExec:   begin phase = PhFetch; done_count = (done_count + 1) % (1 << W); end
        default:  phase = PhHalt;
      endcase
    end
    #1;
  endtask

  task automatic do_reset();
    cycle(1, 7'($urandom), 3'($urandom), 7'($urandom));
    cycle(1, 7'($urandom), 3'($urandom), 7'($urandom));
    cycle(0, 7'($urandom), 3'($urandom), 7'($urandom));
  endtask

  // Garbage opcode during FETCH must not matter; the real one is held through EXECUTE.
  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    cycle(0, 7'($urandom), 3'($urandom), 7'($urandom));
    cycle(0, op, f3, f7);
    cycle(0, op, f3, f7);
  endtask

  task automatic rand_instr();
    logic [6:0] op = LegalOps[$urandom_range(7)];
    logic [2:0] f3 = ($urandom_range(1) == 0) ? 3'b000 : 3'($urandom);
    logic [6:0] f7 = ($urandom_range(1) == 0) ? 7'b0100000 : 7'($urandom);
    instr(op, f3, f7);
  endtask

  // Monitor: every cycle the DUT presents a full control vector and the counter.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      ctl_t act;
      e = exp_q.pop_front();
      act = {sub, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, load_pc, reset_pc,
             pc_next_sel, pc_adder_sel, reset_ir, halted};
      checks++;
      if (act !== e.ctl) begin
        errors++;
        $display("FAIL controls @%0t: got %b expected %b (op %b)", $time, act, e.ctl, opcode);
      end
      checks++;
      if (retired !== e.ret) begin
        errors++;
        $display("FAIL retired @%0t: got %0d expected %0d", $time, retired, e.ret);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // First edge with RST high establishes state; checking starts afterwards.
    @(posedge CLK);
    #1;
    phase = PhBoot;
    done_count = 0;
    do_reset();
    instr(7'b0110011, 3'b000, 7'b0100000);   // R subtract
    instr(7'b0110011, 3'b000, 7'b0000000);   // R add
    instr(7'b0000011, 3'b010, 7'b0000000);   // load
    instr(7'b0100011, 3'b010, 7'b0100000);   // store
    instr(7'b1100111, 3'b000, 7'b0000000);   // jalr
    instr(7'b1101111, 3'b000, 7'b0000000);   // jal
    instr(7'b1100011, 3'b001, 7'b0000000);   // branch
    instr(7'b0010111, 3'b000, 7'b0000000);   // auipc
    instr(7'b0010011, 3'b000, 7'b0100000);   // I-ALU never subtracts
    // Push the 4-bit counter across its wrap point.
    for (int i = 0; i < 12; i++) rand_instr();
    // Reset landing mid-EXECUTE.
    cycle(0, 7'($urandom), 3'($urandom), 7'($urandom));
    cycle(0, 7'b0110011, 3'b000, 7'b0100000);
    do_reset();
    for (int i = 0; i < 16; i++) rand_instr();
    instr(7'b0000011, 3'b000, 7'b0000000);   // 17th: counter wraps to 1
    // Illegal opcode halts and freezes the counter until reset.
    cycle(0, 7'($urandom), 3'($urandom), 7'($urandom));
    cycle(0, 7'b1111111, 3'b000, 7'b0000000);
    for (int i = 0; i < 10; i++) cycle(0, LegalOps[$urandom_range(7)], 3'($urandom), 7'($urandom));
    do_reset();
    for (int i = 0; i < 20; i++) rand_instr();
    @(negedge CLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
